// File: rtl/inst_decode_queue_pkg.sv
// Shared definitions for the instruction decode queue.
// - MIPS opcode / funct / rt encodings used for branch pre-decode.
// - entry_t: one queued instruction with its pre-decoded side flags.
package inst_decode_queue_pkg;

  // Primary opcodes (inst[31:26])
  localparam logic [5:0] OpSpecial = 6'b000000;
  localparam logic [5:0] OpRegimm  = 6'b000001;
  localparam logic [5:0] OpJ       = 6'b000010;
  localparam logic [5:0] OpJal     = 6'b000011;
  localparam logic [5:0] OpBeq     = 6'b000100;
  localparam logic [5:0] OpBne     = 6'b000101;
  localparam logic [5:0] OpBlez    = 6'b000110;
  localparam logic [5:0] OpBgtz    = 6'b000111;

  // SPECIAL funct codes (inst[5:0])
  localparam logic [5:0] FunctJr   = 6'b001000;
  localparam logic [5:0] FunctJalr = 6'b001001;

  // REGIMM rt codes (inst[20:16])
  localparam logic [4:0] RtBltz   = 5'b00000;
  localparam logic [4:0] RtBgez   = 5'b00001;
  localparam logic [4:0] RtBltzal = 5'b10000;
  localparam logic [4:0] RtBgezal = 5'b10001;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        is_branch;
    logic        in_delayslot;
    logic        adel;
  } entry_t;

endpackage

// File: rtl/inst_decode_queue_branch_predecode.sv
// branch_predecode: purely combinational classification of an instruction word.
// Ports:
//   inst_i      - 32-bit instruction word
//   is_branch_o - 1 when the word is a branch or jump (has a delay slot)
module branch_predecode
  import inst_decode_queue_pkg::*;
(
  input  logic [31:0] inst_i,
  output logic        is_branch_o
);

  logic [5:0] opcode;
  logic [4:0] rt;
  logic [5:0] funct;

  assign opcode = inst_i[31:26];
  assign rt     = inst_i[20:16];
  assign funct  = inst_i[5:0];

  always_comb begin
    is_branch_o = 1'b0;
    case (opcode)
      OpJ, OpJal, OpBeq, OpBne, OpBlez, OpBgtz: is_branch_o = 1'b1;
      OpRegimm:  is_branch_o = rt inside {RtBltz, RtBgez, RtBltzal, RtBgezal};
      OpSpecial: is_branch_o = funct inside {FunctJr, FunctJalr};
      default:   is_branch_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/inst_decode_queue.sv
// inst_decode_queue: FIFO between fetch and decode with branch / delay-slot /
// address-error pre-decode. No bypass: an entry is visible one cycle after enqueue.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   flush_i             - drop every queued entry (takes priority over enq/deq)
//   in_valid_i/in_ready_o, in_pc_i, in_inst_i  - fetch side handshake and data
//   out_valid_o/out_ready_i, out_pc_o, out_inst_o, out_is_branch_o,
//   out_in_delayslot_o, out_adel_o             - head entry toward decode
//   count_o             - current occupancy
module inst_decode_queue
  import inst_decode_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      in_pc_i,
  input  logic [31:0]      in_inst_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [31:0]      out_pc_o,
  output logic [31:0]      out_inst_o,
  output logic             out_is_branch_o,
  output logic             out_in_delayslot_o,
  output logic             out_adel_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  entry_t             mem_q [DEPTH];
  logic [PtrW-1:0]    head_q, head_d;
  logic [PtrW-1:0]    tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ds_pend_q, ds_pend_d;

  logic               is_branch;
  logic               enq, deq;
  entry_t             wr_entry;
  entry_t             head_entry;

  branch_predecode u_branch_predecode (
    .inst_i      (in_inst_i),
    .is_branch_o (is_branch)
  );

  // rst is folded in so the fetch side sees "not ready" while reset is held.
  assign in_ready_o  = ~rst & ~flush_i & (count_q < CNT_W'(DEPTH));
  assign out_valid_o = (count_q != '0);

  assign enq = in_valid_i & in_ready_o;
  assign deq = out_valid_o & out_ready_i;

  always_comb begin
    wr_entry              = '0;
    wr_entry.pc           = in_pc_i;
    wr_entry.inst         = in_inst_i;
    wr_entry.is_branch    = is_branch;
    wr_entry.in_delayslot = ds_pend_q;
    wr_entry.adel         = (in_pc_i[1:0] != 2'b00);
  end

  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    ds_pend_d = ds_pend_q;
    if (flush_i) begin
      head_d    = '0;
      tail_d    = '0;
      count_d   = '0;
      ds_pend_d = 1'b0;
    end else begin
      if (enq) begin
        tail_d    = tail_q + PtrW'(1);
        ds_pend_d = is_branch;
      end
      if (deq) begin
        head_d = head_q + PtrW'(1);
      end
      unique case ({enq, deq})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // count_q is the only validity state; clearing it invalidates every entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      ds_pend_q <= 1'b0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      ds_pend_q <= ds_pend_d;
    end
  end

  // Payload storage is not reset; enq already excludes flush and reset.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem_q[tail_q] <= wr_entry;
    end
  end

  always_comb begin
    head_entry = '0;
    if (out_valid_o) begin
      head_entry = mem_q[head_q];
    end
  end

  assign out_pc_o           = head_entry.pc;
  assign out_inst_o         = head_entry.inst;
  assign out_is_branch_o    = head_entry.is_branch;
  assign out_in_delayslot_o = head_entry.in_delayslot;
  assign out_adel_o         = head_entry.adel;
  assign count_o            = count_q;

endmodule

// File: tb/tb_inst_decode_queue.sv
module tb_inst_decode_queue;

  localparam int DEPTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_pc = '0;
  logic [31:0]      in_inst = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_pc;
  logic [31:0]      out_inst;
  logic             out_is_branch;
  logic             out_ds;
  logic             out_adel;
  logic [CNT_W-1:0] count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  inst_decode_queue #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .flush_i            (flush),
    .in_valid_i         (in_valid),
    .in_ready_o         (in_ready),
    .in_pc_i            (in_pc),
    .in_inst_i          (in_inst),
    .out_valid_o        (out_valid),
    .out_ready_i        (out_ready),
    .out_pc_o           (out_pc),
    .out_inst_o         (out_inst),
    .out_is_branch_o    (out_is_branch),
    .out_in_delayslot_o (out_ds),
    .out_adel_o         (out_adel),
    .count_o            (count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    bit          br;
    bit          ds;
    bit          adel;
  } m_t;

  m_t mq[$];
  bit m_ds = 1'b0;
  bit m_enq, m_deq;
  m_t m_e;

  function automatic bit is_br(input logic [31:0] w);
    logic [5:0] op;
    logic [4:0] rt;
    logic [5:0] fn;
    op = w[31:26];
    rt = w[20:16];
    fn = w[5:0];
    if (op >= 6'd2 && op <= 6'd7) return 1'b1;
    if (op == 6'd1) return (rt == 5'd0 || rt == 5'd1 || rt == 5'd16 || rt == 5'd17);
    if (op == 6'd0) return (fn == 6'd8 || fn == 6'd9);
    return 1'b0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst || flush) begin
      mq.delete();
      m_ds = 1'b0;
    end else begin
      m_deq = out_ready && (mq.size() > 0);
      m_enq = in_valid && (mq.size() < DEPTH);
      if (m_deq) void'(mq.pop_front());
      if (m_enq) begin
        m_e.pc   = in_pc;
        m_e.inst = in_inst;
        m_e.br   = is_br(in_inst);
        m_e.ds   = m_ds;
        m_e.adel = (in_pc % 4) != 0;
        mq.push_back(m_e);
        m_ds = m_e.br;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic        e_rdy;
    logic [31:0] e_pc, e_inst;
    logic        e_br, e_ds, e_adel;
    e_rdy  = !rst && !flush && (mq.size() < DEPTH);
    e_pc   = '0;
    e_inst = '0;
    e_br   = 1'b0;
    e_ds   = 1'b0;
    e_adel = 1'b0;
    if (mq.size() > 0) begin
      e_pc   = mq[0].pc;
      e_inst = mq[0].inst;
      e_br   = mq[0].br;
      e_ds   = mq[0].ds;
      e_adel = mq[0].adel;
    end
    chk("m_in_ready", 32'(in_ready), 32'(e_rdy));
    chk("m_out_valid", 32'(out_valid), 32'(mq.size() > 0));
    chk("m_count", 32'(count), 32'(mq.size()));
    chk("m_out_pc", out_pc, e_pc);
    chk("m_out_inst", out_inst, e_inst);
    chk("m_is_branch", 32'(out_is_branch), 32'(e_br));
    chk("m_delayslot", 32'(out_ds), 32'(e_ds));
    chk("m_adel", 32'(out_adel), 32'(e_adel));
  end

  // ---------------- directed stimulus ----------------
  task automatic set_in(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                        input logic rdy, input logic fl);
    in_valid  = v;
    in_pc     = pc;
    in_inst   = inst;
    out_ready = rdy;
    flush     = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic cyc(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                     input logic rdy, input logic fl);
    set_in(v, pc, inst, rdy, fl);
    tick();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2;
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;

    // Enqueue into empty queue: no bypass.
    set_in(1'b1, 32'hBFC00000, 32'h00000000, 1'b0, 1'b0);
    #1;
    chk("nobypass_same_cycle", 32'(out_valid), 32'd0);
    tick();
    chk("first_out_valid", 32'(out_valid), 32'd1);
    chk("first_out_pc", out_pc, 32'hBFC00000);
    chk("first_count", 32'(count), 32'd1);
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("first_drained", 32'(count), 32'd0);

    // Address error on fetch.
    cyc(1'b1, 32'hBFC00002, 32'h0, 1'b0, 1'b0);
    chk("adel_set", 32'(out_adel), 32'd1);
    cyc(1'b1, 32'hBFC00004, 32'h0, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("adel_clear_pc", out_pc, 32'hBFC00004);
    chk("adel_clear", 32'(out_adel), 32'd0);
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Branch followed by delay slot.
    cyc(1'b1, 32'h00000100, 32'h10220003, 1'b0, 1'b0);
    cyc(1'b1, 32'h00000104, 32'h00221821, 1'b0, 1'b0);
    chk("beq_is_branch", 32'(out_is_branch), 32'd1);
    chk("beq_delayslot", 32'(out_ds), 32'd0);
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("addu_is_branch", 32'(out_is_branch), 32'd0);
    chk("addu_delayslot", 32'(out_ds), 32'd1);
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Simultaneous enqueue and dequeue; JR classified as branch.
    cyc(1'b1, 32'h00000200, 32'h03E00008, 1'b0, 1'b0);
    cyc(1'b1, 32'h00000204, 32'h04110010, 1'b0, 1'b0);
    cyc(1'b1, 32'h00000208, 32'h00000000, 1'b1, 1'b0);
    chk("simul_count", 32'(count), 32'd2);
    chk("simul_head_pc", out_pc, 32'h00000204);
    chk("bgezal_delayslot", 32'(out_ds), 32'd1);
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Fill to DEPTH, refuse one more, drain in order (pointers wrap).
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 32'h1000 + 32'(4 * i), 32'h0, 1'b0, 1'b0);
    chk("full_count", 32'(count), 32'd8);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    cyc(1'b1, 32'h00002000, 32'h0, 1'b0, 1'b0);
    chk("full_refuse", 32'(count), 32'd8);
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_pc", out_pc, 32'h1000 + 32'(4 * i));
      cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    end
    chk("drain_empty", 32'(out_valid), 32'd0);

    // Flush with enqueue and dequeue offered.
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'h3000 + 32'(4 * i), 32'h08000000, 1'b0, 1'b0);
    chk("flush_pre_count", 32'(count), 32'd5);
    cyc(1'b1, 32'h00003100, 32'h0, 1'b1, 1'b1);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_out_pc", out_pc, 32'd0);
    cyc(1'b1, 32'h00003200, 32'h0, 1'b0, 1'b0);
    chk("flush_ds_clear", 32'(out_ds), 32'd0);
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Asynchronous reset mid-operation with a pending delay slot.
    cyc(1'b1, 32'h00004000, 32'h0, 1'b0, 1'b0);
    cyc(1'b1, 32'h00004004, 32'h0, 1'b0, 1'b0);
    cyc(1'b1, 32'h00004008, 32'h08000000, 1'b0, 1'b0);
    set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("prereset_count", 32'(count), 32'd3);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_count", 32'(count), 32'd0);
    chk("async_rst_ready", 32'(in_ready), 32'd0);
    chk("async_rst_pc", out_pc, 32'd0);
    tick();
    rst = 1'b0;
    cyc(1'b1, 32'h00005000, 32'h00221821, 1'b0, 1'b0);
    chk("post_rst_valid", 32'(out_valid), 32'd1);
    chk("post_rst_delayslot", 32'(out_ds), 32'd0);
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_decode_queue.md
INST_DECODE_QUEUE -- requirements
Module: inst_decode_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, queue entries; power of two, >= 2.
REQ-002 SHALL have parameter CNT_W, default $clog2(DEPTH)+1, occupancy counter width.
REQ-003 SHALL have port clk  input  1  single clock; all state samples on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port flush_i  input  1  discard all queued entries (exception, ERET, branch redirect).
REQ-006 SHALL have port in_valid_i  input  1  fetch offers an instruction.
REQ-007 SHALL have port in_ready_o  output  1  queue accepts an instruction.
REQ-008 SHALL have port in_pc_i  input  32  fetch address.
REQ-009 SHALL have port in_inst_i  input  32  fetched instruction word.
REQ-010 SHALL have port out_valid_o  output  1  head entry valid toward ID.
REQ-011 SHALL have port out_ready_i  input  1  ID consumes the head (not stalled).
REQ-012 SHALL have port out_pc_o  output  32  head PC.
REQ-013 SHALL have port out_inst_o  output  32  head instruction.
REQ-014 SHALL have port out_is_branch_o  output  1  head is a branch or jump (pre-decoded).
REQ-015 SHALL have port out_in_delayslot_o  output  1  head sits in a delay slot.
REQ-016 SHALL have port out_adel_o  output  1  head PC misaligned (address-error-on-fetch flag).
REQ-017 SHALL have port count_o  output  CNT_W  current occupancy.

Function
REQ-018 in_ready_o SHALL be 1 iff count_o < DEPTH and flush_i = 0; out_valid_o SHALL be 1 iff count_o > 0.
REQ-019 Enqueue SHALL occur on a cycle with in_valid_i & in_ready_o; dequeue on out_valid_o & out_ready_i.
REQ-020 Entry write SHALL store {pc, inst, is_branch, in_delayslot, adel} at the tail; tail pointer increments modulo DEPTH.
REQ-021 Head outputs SHALL be read combinationally from storage at the head pointer; head increments modulo DEPTH on dequeue.
REQ-022 No bypass: an instruction enqueued into an empty queue SHALL appear on out_valid_o one cycle later.
REQ-023 Simultaneous enqueue and dequeue SHALL leave count_o unchanged; full queue accepts nothing that cycle (in_ready_o = 0).
REQ-024 is_branch SHALL be 1 for opcodes 000010 J, 000011 JAL, 000100 BEQ, 000101 BNE, 000110 BLEZ, 000111 BGTZ; opcode 000001 with rt in {00000, 00001, 10000, 10001}; opcode 000000 with funct 001000 JR or 001001 JALR; else 0.
REQ-025 adel SHALL be 1 iff in_pc_i[1:0] != 2'b00.
REQ-026 Register ds_pend SHALL be set on enqueue of a branch, cleared on enqueue of a non-branch; enqueued in_delayslot = ds_pend before update.
REQ-027 flush_i SHALL take priority: next cycle count_o = 0, both pointers = 0, ds_pend = 0; enqueue and dequeue in a flush cycle have no effect.
REQ-028 When out_valid_o = 0, out_* data outputs SHALL be 0.

Reset
REQ-029 rst SHALL asynchronously clear pointers, count, ds_pend and all entry valid state; during reset in_ready_o = 0, out_valid_o = 0, count_o = 0, all out_* = 0.
REQ-030 Reset asserted mid-operation SHALL discard all entries; first enqueue after release SHALL have in_delayslot = 0.
REQ-031 Storage data arrays need no reset.

Structure
REQ-032 Opcode/funct/rt branch encodings SHALL come from the shared defines package, not literals in the module; entry struct typedef SHALL live in the shared package.
REQ-033 One sub-module SHALL be used: branch_predecode (pure combinational inst -> is_branch).

Verification
REQ-034 Enqueue 0x00000000 @ pc 0xBFC00000 into empty queue -> out_valid_o = 0 same cycle, 1 next cycle, out_pc_o = 0xBFC00000, count_o = 1.
REQ-035 Fill with DEPTH=8 entries, out_ready_i = 0 -> count_o = 8, in_ready_o = 0; 9th offer not accepted; drain -> PCs in order, pointers wrap correctly.
REQ-036 Enqueue BEQ 0x10220003 then ADDU 0x00221821 -> first out_is_branch_o = 1, in_delayslot = 0; second out_is_branch_o = 0, in_delayslot = 1.
REQ-037 Queue holding 5 entries, flush_i with in_valid_i = 1 and out_ready_i = 1 -> next cycle count_o = 0, out_valid_o = 0, nothing enqueued.
REQ-038 Enqueue pc 0xBFC00002 -> out_adel_o = 1; pc 0xBFC00004 -> out_adel_o = 0.
REQ-039 Assert rst asynchronously with 3 entries, ds_pend = 1 -> outputs clear without clock edge; next enqueue after release has in_delayslot = 0.
